// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter: round-robin share of one immediate sign-extender
// between the load/store unit (port 0) and the branch/jump unit (port 1).
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req0_valid/ready      port 0 handshake
//   req0_imm, req0_long   port 0 immediate, 1 = JIMM_W-bit immediate
//   req1_valid/ready      port 1 handshake
//   req1_imm, req1_long   port 1 immediate, 1 = JIMM_W-bit (jal)
//   out_valid/ready       registered result slot handshake
//   out_data, out_id      sign-extended immediate and requester id
module imm_ext_arbiter #(
  parameter int XLEN   = 32,
  parameter int IMM_W  = 12,
  parameter int JIMM_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [JIMM_W-1:0] req0_imm,
  input  logic              req0_long,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [JIMM_W-1:0] req1_imm,
  input  logic              req1_long,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic              out_id
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic last_grant;
  logic can_accept;
  logic grant0;
  logic grant1;
  logic fire;

  logic [JIMM_W-1:0] sel_imm;
  logic              sel_long;
  logic [XLEN-1:0]   ext_data;

  function automatic logic [XLEN-1:0] ext(
    input logic [JIMM_W-1:0] imm,
    input logic              lng
  );
    logic [XLEN-1:0] r;
    if (lng) begin
      r = {{(XLEN-JIMM_W){imm[JIMM_W-1]}}, imm};
    end else begin
      r = {{(XLEN-IMM_W){imm[IMM_W-1]}},
           imm[IMM_W-1:0]};
    end
    return r;
  endfunction

  assign can_accept = (state == EMPTY) | out_ready;

  // Items are mutually exclusive so the unique check holds.
  // On a tie, last_grant=1 means port 0 goes next.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (can_accept) begin
      unique case (1'b1)
        (req0_valid & req1_valid): begin
          grant0 = last_grant;
          grant1 = ~last_grant;
        end
        (req0_valid & ~req1_valid): begin
          grant0 = 1'b1;
        end
        (~req0_valid & req1_valid): begin
          grant1 = 1'b1;
        end
        default: begin
          grant0 = 1'b0;
          grant1 = 1'b0;
        end
      endcase
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign fire       = grant0 | grant1;

  assign sel_imm  = grant1 ? req1_imm  : req0_imm;
  assign sel_long = grant1 ? req1_long : req0_long;
  assign ext_data = ext(sel_imm, sel_long);

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: begin
        if (fire) state_nxt = FULL;
      end
      FULL: begin
        if (fire) begin
          state_nxt = FULL;
        end else if (out_ready) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  assign out_valid = (state == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      last_grant <= 1'b1;
      out_data   <= '0;
      out_id     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (fire) begin
        out_data   <= ext_data;
        out_id     <= grant1;
        last_grant <= grant1;
      end
    end
  end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// tb_imm_ext_arbiter: directed plus random stimulus for imm_ext_arbiter,
// scoreboard queue filled by the driver and drained by a monitor.
module tb_imm_ext_arbiter;
  localparam int XLEN   = 32;
  localparam int IMM_W  = 12;
  localparam int JIMM_W = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid = 1'b0;
  logic req0_long = 1'b0;
  logic req1_valid = 1'b0;
  logic req1_long = 1'b0;
  logic out_ready = 1'b0;
  logic [JIMM_W-1:0] req0_imm = '0;
  logic [JIMM_W-1:0] req1_imm = '0;
  logic req0_ready;
  logic req1_ready;
  logic out_valid;
  logic out_id;
  logic [XLEN-1:0] out_data;

  always #5 clk = ~clk;

  imm_ext_arbiter #(
    .XLEN(XLEN), .IMM_W(IMM_W), .JIMM_W(JIMM_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_imm(req0_imm), .req0_long(req0_long),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_imm(req1_imm), .req1_long(req1_long),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id)
  );

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            id;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passed = 0;
  bit m_last = 1'b1;
  bit m_full = 1'b0;

  // Reference extension: two's-complement value of the immediate field.
  function automatic logic [31:0] ref_ext(
    input logic [19:0] imm, input bit lng);
    longint v;
    if (lng) begin
      v = longint'(imm);
      if (imm[19]) v = v - (longint'(1) << 20);
    end else begin
      v = longint'(imm[11:0]);
      if (imm[11]) v = v - 4096;
    end
    return v[31:0];
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic expect_out(input string name, input bit v,
                            input logic [31:0] d, input bit id);
    check({name, " valid"}, {31'b0, out_valid}, {31'b0, v});
    check({name, " data"}, out_data, d);
    check({name, " id"}, {31'b0, out_id}, {31'b0, id});
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("mon out_valid", {31'b0, out_valid},
            {31'b0, q.size() != 0});
      if (out_valid && q.size() > 0) begin
        check("mon out_data", out_data, q[0].data);
        check("mon out_id", {31'b0, out_id}, {31'b0, q[0].id});
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  // One clock of stimulus; called at posedge+1, returns at next posedge+1.
  task automatic cycle(input bit v0, input logic [19:0] i0, input bit l0,
                       input bit v1, input logic [19:0] i1, input bit l1,
                       input bit ordy, output bit g0, output bit g1);
    bit acc;
    exp_t e;
    req0_valid = v0; req0_imm = i0; req0_long = l0;
    req1_valid = v1; req1_imm = i1; req1_long = l1;
    out_ready = ordy;
    @(negedge clk); #1;
    acc = !m_full || ordy;
    g0 = acc && v0 && (!v1 || m_last);
    g1 = acc && v1 && (!v0 || !m_last);
    check("req0_ready", {31'b0, req0_ready}, {31'b0, g0});
    check("req1_ready", {31'b0, req1_ready}, {31'b0, g1});
    if (g0 || g1) begin
      e.data = ref_ext(g1 ? i1 : i0, g1 ? l1 : l0);
      e.id = g1;
      q.push_back(e);
      m_last = g1;
    end
    m_full = g0 || g1 || (m_full && !ordy);
    @(posedge clk); #1;
  endtask

  task automatic idle(input bit ordy);
    bit a, b;
    cycle(0, '0, 0, 0, '0, 0, ordy, a, b);
  endtask

  initial begin
    bit g0, g1;
    bit p0, p1;
    logic [19:0] ri0, ri1;
    bit rl0, rl1;
    logic [31:0] held;

    #12;
    expect_out("reset", 0, 32'h0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    cycle(1, 20'h00800, 0, 0, '0, 0, 1, g0, g1);
    expect_out("t1 short neg", 1, 32'hFFFFF800, 0);
    cycle(0, '0, 0, 1, 20'h80000, 1, 1, g0, g1);
    expect_out("t2 long neg", 1, 32'hFFF80000, 1);
    cycle(0, '0, 0, 1, 20'hAB7FF, 0, 1, g0, g1);
    expect_out("t2 short pos", 1, 32'h000007FF, 1);
    idle(1);

    for (int i = 0; i < 6; i++) begin
      cycle(1, 20'($urandom), 1'($urandom), 1, 20'($urandom),
            1'($urandom), 1, g0, g1);
      expect_out("t3 rr", 1, out_data, 1'(i % 2));
    end

    held = out_data;
    ri0 = 20'($urandom); ri1 = 20'($urandom);
    for (int i = 0; i < 4; i++) begin
      cycle(1, ri0, 0, 1, ri1, 1, 0, g0, g1);
      expect_out("t4 stall", 1, held, 1);
    end
    cycle(1, ri0, 0, 1, ri1, 1, 1, g0, g1);
    expect_out("t4 reload", 1, ref_ext(ri0, 0), 0);

    cycle(1, ri0, 0, 1, ri1, 1, 0, g0, g1);
    #2 rst_n = 1'b0;
    #1 expect_out("t5 reset", 0, 32'h0, 0);
    q.delete();
    m_full = 0;
    m_last = 1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(1, 20'h00123, 0, 1, 20'h00456, 0, 1, g0, g1);
    expect_out("t5 tie", 1, 32'h00000123, 0);

    cycle(1, 20'h00FFF, 0, 0, '0, 0, 1, g0, g1);
    expect_out("t6 solo", 1, 32'hFFFFFFFF, 0);
    idle(1); idle(1); idle(1);
    cycle(1, 20'h00001, 0, 1, 20'hFFFFF, 1, 1, g0, g1);
    expect_out("t6 tie", 1, 32'hFFFFFFFF, 1);
    idle(1);

    p0 = 0; p1 = 0;
    ri0 = '0; ri1 = '0; rl0 = 0; rl1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && ($urandom_range(2) != 0)) begin
        p0 = 1; ri0 = 20'($urandom); rl0 = 1'($urandom);
      end
      if (!p1 && ($urandom_range(2) != 0)) begin
        p1 = 1; ri1 = 20'($urandom); rl1 = 1'($urandom);
      end
      cycle(p0, p0 ? ri0 : 20'($urandom), rl0,
            p1, p1 ? ri1 : 20'($urandom), rl1,
            ($urandom_range(9) < 7), g0, g1);
      if (g0) p0 = 0;
      if (g1) p1 = 0;
    end
    idle(1); idle(1);
    check("drained", q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
